// File: rtl/receiver_uart_pkg.sv
// ============================================================================
// Module      : receiver_uart_pkg
// Description : UART 8N1 frame constants, FSM state encoding and baud divider
// Revision    : 1.0
// ============================================================================
`default_nettype none

package receiver_uart_pkg;

    localparam int C_DATA_BITS = 8;
    localparam int C_STOP_BITS = 1;

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } uart_state_t;

    // Clocks per bit, rounded to nearest.
    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer for an asynchronous idle-high input
// Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic [1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_async};
        end
    end

    assign o_sync = r_sync[1];

endmodule

`default_nettype wire

// File: rtl/receiver_uart.sv
// ============================================================================
// Module      : receiver_uart
// Description : UART 8N1 receiver with a one-byte AXI-stream style output
// Revision    : 1.0
// ============================================================================
`default_nettype none

module receiver_uart
    import receiver_uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 16000000,
    parameter int BAUD_RATE   = 57600
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    output logic [7:0] o_tdata,
    output logic       o_tvalid,
    input  logic       i_tready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int C_DIV   = uart_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int C_HALF  = C_DIV / 2;
    localparam int C_CNT_W = $clog2(C_DIV);
    localparam int C_IDX_W = $clog2(C_DATA_BITS);

    generate
        if (C_DIV < 4) begin : g_div_check
            $error("receiver_uart: clocks per bit must be at least 4");
        end
    endgenerate

    logic                   w_rx_s;
    uart_state_t            r_state;
    uart_state_t            w_state_n;
    logic [C_CNT_W-1:0]     r_cnt;
    logic [C_CNT_W-1:0]     w_cnt_n;
    logic [C_IDX_W-1:0]     r_idx;
    logic [C_IDX_W-1:0]     w_idx_n;
    logic [C_DATA_BITS-1:0] r_shift;
    logic [C_DATA_BITS-1:0] w_shift_n;
    logic [1:0]             r_primed;
    logic                   w_tick;
    logic                   w_deliver;
    logic                   w_frame_err;

    uart_rx_sync u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_uart_rx),
        .o_sync  (w_rx_s)
    );

    assign w_tick = (r_cnt == '0);

    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = w_tick ? C_CNT_W'(C_DIV - 1) : (r_cnt - 1'b1);
        w_idx_n     = r_idx;
        w_shift_n   = r_shift;
        w_deliver   = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            WAIT_IDLE: begin
                // The synchronizer's reset value of 1 is not a real line
                // observation, so wait until it has been flushed.
                if (r_primed[1] && w_rx_s) begin
                    w_state_n = IDLE;
                end
            end
            IDLE: begin
                if (!w_rx_s) begin
                    w_cnt_n   = C_CNT_W'(C_HALF - 1);
                    w_state_n = START;
                end
            end
            START: begin
                if (w_tick) begin
                    if (!w_rx_s) begin
                        w_idx_n   = '0;
                        w_state_n = DATA;
                    end else begin
                        w_state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_n = {w_rx_s, r_shift[C_DATA_BITS-1:1]};
                    w_idx_n   = r_idx + 1'b1;
                    if (r_idx == C_IDX_W'(C_DATA_BITS - 1)) begin
                        w_state_n = STOP;
                    end
                end
            end
            STOP: begin
                // Leave mid-stop-bit so a back-to-back start edge is caught.
                if (w_tick) begin
                    if (w_rx_s) begin
                        w_deliver = 1'b1;
                        w_state_n = IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_n   = WAIT_IDLE;
                    end
                end
            end
            default: begin
                w_state_n = WAIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= WAIT_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_primed <= '0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_idx    <= w_idx_n;
            r_shift  <= w_shift_n;
            r_primed <= {r_primed[0], 1'b1};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_tdata     <= '0;
            o_tvalid    <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= w_frame_err;
            o_overrun   <= 1'b0;
            if (w_deliver) begin
                if (!o_tvalid || i_tready) begin
                    o_tdata  <= r_shift;
                    o_tvalid <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_tvalid && i_tready) begin
                o_tvalid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/receiver_uart.md
Name: receiver_uart

Overview:
- UART receiver (8N1) producing an 8-bit AXI-stream-style byte output (tdata/tvalid/tready).
- Receive-side counterpart of emitter_uart. Turns the board's serial RX pin into bytes for a downstream consumer, e.g. a command/loopback path next to corescorecore.
- Oversamples with a baud-rate divider, samples each bit at mid-period, checks the stop bit, and holds one received byte until it is accepted.

Parameters:
- clk_freq_hz, 16000000, frequency of i_clk in Hz.
- baud_rate, 57600, line rate in bit/s.
- Derived localparam DIV = (clk_freq_hz + baud_rate/2) / baud_rate, i.e. clocks per bit, rounded. Elaboration error if DIV < 4.
- Derived localparam HALF = DIV/2.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset; synchronous, active-high
- i_uart_rx  in  1  asynchronous serial input, idle high
- o_tdata  out  8  received byte; stable while o_tvalid=1
- o_tvalid  out  1  byte available
- i_tready  in  1  consumer accepts the byte when o_tvalid and i_tready are both 1
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low
- o_overrun  out  1  one-cycle pulse: new byte dropped because the holding register was full

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous, active-high.
- Synchronizer: 2-flop on i_uart_rx, both flops reset to 1. All logic uses the synced value rx_s (2-cycle input latency).
- Reset values: o_tdata=0, o_tvalid=0, o_frame_err=0, o_overrun=0, state=WAIT_IDLE, counter=0, bit index=0.
- Baud counter: down-counter, width $clog2(DIV). A "tick" occurs when the counter is 0; on a tick it reloads DIV-1.
- FSM states:
  - WAIT_IDLE: stay until rx_s=1, then go to IDLE. Prevents a line held low (reset mid-frame, break) from being taken as a start bit.
  - IDLE: on rx_s=0, load counter HALF-1 and go to START.
  - START: on tick, sample rx_s.
    - If 0 (valid start): reload DIV-1, clear bit index, go to DATA.
    - If 1 (glitch shorter than half a bit): go to IDLE with no outputs.
  - DATA: on each tick, shift rx_s into the MSB of the shift register (LSB first on the line) and increment bit index. After the 8th sample, go to STOP.
  - STOP: on tick, sample rx_s.
    - If 1: deliver the byte and go to IDLE immediately (mid-stop-bit), so the receiver is re-armed for back-to-back frames.
    - If 0: pulse o_frame_err for 1 cycle, discard the byte, go to WAIT_IDLE.
- Delivery (cycle after the stop-bit sample):
  - o_tvalid=0: load o_tdata, set o_tvalid=1.
  - o_tvalid=1 and i_tready=1 in the delivery cycle: old byte consumed, new byte loaded, o_tvalid stays 1, no overrun.
  - o_tvalid=1 and i_tready=0: new byte dropped, o_tdata unchanged, o_overrun pulses 1 cycle.
- Handshake:
  - o_tvalid clears the cycle after o_tvalid & i_tready when no delivery coincides.
  - o_tvalid never drops without a handshake.
  - o_tdata never changes while o_tvalid=1, except on a handshake cycle.
- Latency: o_tvalid rises 2 sync cycles + 1 + HALF + 9*DIV cycles after the start-bit falling edge on the pin (±1 cycle).
- Reset mid-frame: partial byte discarded, held byte discarded (o_tvalid=0), FSM in WAIT_IDLE.
- Error outputs are pulses only. No sticky status.

Decomposition:
- Shared uart package/include, shared with emitter_uart: state encoding constants (WAIT_IDLE, IDLE, START, DATA, STOP), the DIV rounding expression, and the 8N1 frame constants (data bits = 8, stop bits = 1).
- One natural sub-module: uart_rx_sync (2-flop synchronizer, reset to 1), reusable for other async pins.
- Everything else stays flat.

Test Plan:
All scenarios use clk_freq_hz=16000000, baud_rate=1000000, so DIV=16, HALF=8.
1. Send 0x55 (correct stop), i_tready=1 -> one-cycle o_tvalid with o_tdata=0x55 about 154 cycles after the falling edge; o_frame_err=0, o_overrun=0.
2. Send 0xA5 then 0x3C back-to-back, i_tready=0 throughout -> o_tdata=0xA5 held; o_overrun pulses once at the 0x3C delivery; later i_tready=1 -> 0xA5 accepted, then o_tvalid=0, no 0x3C.
3. Send 0x81 with stop bit 0, then hold the line low for 20 bit times, then high, then send 0x12 -> exactly one o_frame_err pulse, no byte for 0x81, no spurious bytes while low, then 0x12 received.
4. Drive a 4-cycle low glitch (< HALF) -> no o_tvalid, no error pulses; next frame 0x7E received correctly.
5. Assert i_rst after 3 data bits with the line still low at reset release -> no byte until the line returns high; next frame 0xFF received correctly.
6. Hold 0x11 unaccepted; assert i_tready exactly in the 0x22 delivery cycle -> no o_overrun; o_tvalid stays 1; o_tdata=0x22 on the next cycle.
